signal_switch_sequencer: RTL and testbench
==========================================

Name: signal_switch_sequencer

Overview:
- Controls the A/B source selection in front of the signal processing chain.
- Selects and registers one of two sample streams (a, b).
- On every source change, inserts a configurable blanking gap with zero output and `y_valid` low, so downstream filters and FFT never see a mixed or glitching transition.
- Switches either on software request (manual) or by alternating automatically after a programmable dwell time.

Parameters:
- DATA_WIDTH, 16, width of samples a, b, y.
- DWELL_WIDTH, 24, width of dwell counter / cfg_dwell.
- BLANK_WIDTH, 8, width of blanking counter / cfg_blank.

Ports:
- aclk  in  1  system clock, rising edge.
- aresetn  in  1  asynchronous active-low reset.
- a  in  DATA_WIDTH  source A sample, valid every cycle.
- b  in  DATA_WIDTH  source B sample, valid every cycle.
- cfg_auto  in  1  1 = automatic alternation, 0 = manual.
- cfg_dwell  in  DWELL_WIDTH  HOLD cycles per source in auto mode; 0 disables auto switching.
- cfg_blank  in  BLANK_WIDTH  blanking length in cycles; 0 behaves as 1.
- sel_req  in  1  manual target source (0 = A, 1 = B).
- y  out  DATA_WIDTH  registered selected sample.
- y_valid  out  1  high when y carries a real sample.
- sel  out  1  currently committed source.
- busy  out  1  high while in BLANK.

Behaviour:
- Reset (aresetn low, any time including mid-BLANK): state=HOLD, sel=0, y=0, y_valid=0, busy=0, dwell_cnt=0, blank_cnt=0, blank_len=0. Takes effect immediately.
- HOLD, no switch pending: each edge y<=(sel ? b : a), y_valid<=1. Latency a/b -> y is 1 cycle. First valid y is at the first edge after reset release.
- Switch condition (HOLD only):
  - Manual: cfg_auto=0 and sel_req!=sel.
  - Auto: cfg_auto=1, cfg_dwell!=0 and dwell_cnt>=cfg_dwell-1. Using >= means a lowered cfg_dwell switches on the next cycle.
- dwell_cnt:
  - Increments each HOLD cycle while cfg_auto=1.
  - Cleared on entry to BLANK, and while cfg_auto=0.
  - In auto mode sel_req is ignored.
- HOLD -> BLANK, on the edge where the switch condition holds:
  - y<=0, y_valid<=0, busy<=1, blank_cnt<=0.
  - blank_len<=max(cfg_blank,1), latched here. cfg_blank changes during BLANK have no effect.
- BLANK:
  - y=0, y_valid=0, blank_cnt increments each cycle.
  - sel_req and cfg_auto changes are ignored; the target is always ~sel.
  - When blank_cnt==blank_len-1, on that edge: state<=HOLD, sel<=~sel, busy<=0, y<=new source sample, y_valid<=1.
- Gap guarantee: y_valid is low for exactly blank_len consecutive cycles per switch. The old and new source never appear within that gap.
- Manual request arriving during BLANK: evaluated on the first HOLD cycle. If sel_req still differs from the new sel, a further switch starts after one valid cycle.
- Auto mode with cfg_dwell=1: the pattern is 1 valid cycle, then blank_len blank cycles, repeating.
- Arithmetic: counters are unsigned, compare-and-clear, no wrap reachable. y is passed through unmodified; no sign handling is needed.

Optional Feature:
- Macro: SIGNAL_SWITCH_STATS_EN.
- When defined, adds output switch_count (16 bit, unsigned):
  - reset value 0;
  - increments on each BLANK -> HOLD transition;
  - saturates at 16'hFFFF.
- When undefined, the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset release with a=14, b=-29 (16'hFFE3), cfg_auto=0, sel_req=0 -> one edge later y=14, y_valid=1, sel=0, busy=0.
- Manual: cfg_blank=3, set sel_req=1 -> y=0 and y_valid=0 for exactly 3 cycles, busy=1 during them, then y=16'hFFE3, sel=1. Then a=7, b=16 -> y=16 one cycle later.
- Auto: cfg_auto=1, cfg_dwell=5, cfg_blank=2 -> repeating pattern of 5 valid cycles and 2 blank cycles, sel toggling 0,1,0,… Lower cfg_dwell to 2 mid-dwell at count 4 -> switch begins on the next cycle.
- cfg_blank=0 -> exactly 1 blank cycle. cfg_blank changed 3->10 during BLANK -> gap stays 3. cfg_dwell=0 with cfg_auto=1 -> no switching over 100 cycles.
- aresetn pulsed low in the 2nd BLANK cycle -> y=0, y_valid=0, sel=0, busy=0 immediately; normal HOLD on A after release.
- With SIGNAL_SWITCH_STATS_EN: after 4 switches switch_count=4. Force the counter to 16'hFFFF -> it holds after a further switch.

Source files
------------

// File: rtl/signal_switch_sequencer_if.sv
// Source-selection bus: sample inputs, configuration and registered output.
// Optional switch_count appears only when SIGNAL_SWITCH_STATS_EN is defined.
`default_nettype none

interface signal_switch_sequencer_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int DWELL_WIDTH = 24,
  parameter int BLANK_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]  a;
  logic [DATA_WIDTH-1:0]  b;
  logic                   cfg_auto;
  logic [DWELL_WIDTH-1:0] cfg_dwell;
  logic [BLANK_WIDTH-1:0] cfg_blank;
  logic                   sel_req;
  logic [DATA_WIDTH-1:0]  y;
  logic                   y_valid;
  logic                   sel;
  logic                   busy;
`ifdef SIGNAL_SWITCH_STATS_EN
  logic [15:0]            switch_count;
`endif

  modport master (
    output a, b, cfg_auto, cfg_dwell, cfg_blank, sel_req,
`ifdef SIGNAL_SWITCH_STATS_EN
    input  switch_count,
`endif
    input  y, y_valid, sel, busy
  );

  modport slave (
    input  a, b, cfg_auto, cfg_dwell, cfg_blank, sel_req,
`ifdef SIGNAL_SWITCH_STATS_EN
    output switch_count,
`endif
    output y, y_valid, sel, busy
  );
endinterface

`default_nettype wire

// File: rtl/signal_switch_sequencer.sv
// ============================================================================
// signal_switch_sequencer: A/B source select with zero-output blanking gap
// on every switch; manual or dwell-timed automatic alternation.
// Optional macro SIGNAL_SWITCH_STATS_EN adds a saturating switch_count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module signal_switch_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int DWELL_WIDTH = 24,
  parameter int BLANK_WIDTH = 8
) (
  input  wire                      aclk,
  input  wire                      aresetn,
  signal_switch_sequencer_if.slave bus
);

  typedef enum logic [0:0] {
    ST_HOLD  = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  state_t                 state, state_next;
  logic                   sel_reg, sel_next;
  logic [DATA_WIDTH-1:0]  y_reg, y_next;
  logic                   y_valid_reg, y_valid_next;
  logic                   busy_reg, busy_next;
  logic [DWELL_WIDTH-1:0] dwell_cnt, dwell_next;
  logic [BLANK_WIDTH-1:0] blank_cnt, blank_cnt_next;
  logic [BLANK_WIDTH-1:0] blank_len, blank_len_next;

  logic manual_hit;
  logic auto_hit;
  logic switch_req;

  // >= rather than == so a lowered cfg_dwell takes effect on the next cycle
  assign manual_hit = !bus.cfg_auto && (bus.sel_req != sel_reg);
  assign auto_hit   = bus.cfg_auto && (bus.cfg_dwell != '0) &&
                      (dwell_cnt >= (bus.cfg_dwell - DWELL_WIDTH'(1)));
  assign switch_req = manual_hit || auto_hit;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= ST_HOLD;
      sel_reg     <= 1'b0;
      y_reg       <= '0;
      y_valid_reg <= 1'b0;
      busy_reg    <= 1'b0;
      dwell_cnt   <= '0;
      blank_cnt   <= '0;
      blank_len   <= '0;
    end else begin
      state       <= state_next;
      sel_reg     <= sel_next;
      y_reg       <= y_next;
      y_valid_reg <= y_valid_next;
      busy_reg    <= busy_next;
      dwell_cnt   <= dwell_next;
      blank_cnt   <= blank_cnt_next;
      blank_len   <= blank_len_next;
    end
  end

  always_comb begin
    state_next     = state;
    sel_next       = sel_reg;
    y_next         = y_reg;
    y_valid_next   = y_valid_reg;
    busy_next      = busy_reg;
    dwell_next     = dwell_cnt;
    blank_cnt_next = blank_cnt;
    blank_len_next = blank_len;

    case (state)
      ST_HOLD: begin
        if (switch_req) begin
          state_next     = ST_BLANK;
          y_next         = '0;
          y_valid_next   = 1'b0;
          busy_next      = 1'b1;
          blank_cnt_next = '0;
          dwell_next     = '0;
          // Gap length is frozen here; later cfg_blank edits wait for the next switch
          blank_len_next = (bus.cfg_blank == '0) ? BLANK_WIDTH'(1) : bus.cfg_blank;
        end else begin
          y_next       = sel_reg ? bus.b : bus.a;
          y_valid_next = 1'b1;
          busy_next    = 1'b0;
          if (!bus.cfg_auto) begin
            dwell_next = '0;
          end else if (dwell_cnt != '1) begin
            dwell_next = dwell_cnt + DWELL_WIDTH'(1);
          end
        end
      end

      ST_BLANK: begin
        y_next       = '0;
        y_valid_next = 1'b0;
        if (blank_cnt == (blank_len - BLANK_WIDTH'(1))) begin
          state_next   = ST_HOLD;
          sel_next     = ~sel_reg;
          busy_next    = 1'b0;
          y_next       = sel_reg ? bus.a : bus.b;
          y_valid_next = 1'b1;
        end else begin
          blank_cnt_next = blank_cnt + BLANK_WIDTH'(1);
        end
      end

      default: begin
        state_next = ST_HOLD;
      end
    endcase
  end

  assign bus.y       = y_reg;
  assign bus.y_valid = y_valid_reg;
  assign bus.sel     = sel_reg;
  assign bus.busy    = busy_reg;

`ifdef SIGNAL_SWITCH_STATS_EN
  logic [15:0] switch_count_reg;
  logic        switch_done;

  assign switch_done = (state == ST_BLANK) && (state_next == ST_HOLD);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      switch_count_reg <= '0;
    end else if (switch_done && (switch_count_reg != 16'hFFFF)) begin
      switch_count_reg <= switch_count_reg + 16'd1;
    end
  end

  assign bus.switch_count = switch_count_reg;
`endif

endmodule

`default_nettype wire

// File: tb/tb_signal_switch_sequencer.sv
// Directed testbench for signal_switch_sequencer with hand-computed expectations.
`default_nettype none

module tb_signal_switch_sequencer;

  logic aclk;
  logic aresetn;
  int   n_checks;
  int   n_passed;
  int   cnt;
  logic exp_sel;

  signal_switch_sequencer_if #(.DATA_WIDTH(16), .DWELL_WIDTH(24), .BLANK_WIDTH(8)) bus ();

  signal_switch_sequencer #(
    .DATA_WIDTH (16),
    .DWELL_WIDTH(24),
    .BLANK_WIDTH(8)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .bus    (bus.slave)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Counts consecutive cycles with y_valid low, starting at the current cycle.
  task automatic gap(output int n);
    n = 0;
    while (!bus.y_valid && n < 64) begin
      n++;
      tick();
    end
  endtask

  // Counts consecutive cycles with y_valid high, starting at the current cycle.
  task automatic run(output int n);
    n = 0;
    while (bus.y_valid && n < 64) begin
      n++;
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_passed = 0;
    aresetn       = 1'b0;
    bus.a         = 16'd14;
    bus.b         = 16'hFFE3;
    bus.cfg_auto  = 1'b0;
    bus.cfg_dwell = 24'd0;
    bus.cfg_blank = 8'd3;
    bus.sel_req   = 1'b0;
    tick();
    tick();
    check("rst_y", 32'(bus.y), 32'd0);
    check("rst_valid", 32'(bus.y_valid), 32'd0);
    check("rst_sel", 32'(bus.sel), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    aresetn = 1'b1;
    tick();
    check("first_y", 32'(bus.y), 32'd14);
    check("first_valid", 32'(bus.y_valid), 32'd1);
    check("first_sel", 32'(bus.sel), 32'd0);
    check("first_busy", 32'(bus.busy), 32'd0);

    // Manual switch to B with a 3-cycle gap
    bus.sel_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("man_gap_valid", 32'(bus.y_valid), 32'd0);
      check("man_gap_y", 32'(bus.y), 32'd0);
      check("man_gap_busy", 32'(bus.busy), 32'd1);
    end
    tick();
    check("man_new_y", 32'(bus.y), 32'h0000FFE3);
    check("man_new_sel", 32'(bus.sel), 32'd1);
    check("man_new_busy", 32'(bus.busy), 32'd0);
    bus.a = 16'd7;
    bus.b = 16'd16;
    tick();
    check("man_track_y", 32'(bus.y), 32'd16);

    // cfg_blank raised mid-gap must not stretch the latched length
    bus.sel_req = 1'b0;
    tick();
    bus.cfg_blank = 8'd10;
    gap(cnt);
    check("latched_gap", 32'(cnt), 32'd3);
    check("latched_sel", 32'(bus.sel), 32'd0);
    check("latched_y", 32'(bus.y), 32'd7);

    // cfg_blank = 0 behaves as a single blank cycle
    bus.cfg_blank = 8'd0;
    bus.sel_req   = 1'b1;
    tick();
    gap(cnt);
    check("blank0_gap", 32'(cnt), 32'd1);
    check("blank0_sel", 32'(bus.sel), 32'd1);
    check("blank0_y", 32'(bus.y), 32'd16);

    // Auto alternation: 5 valid, 2 blank, sel toggling
    bus.cfg_auto  = 1'b1;
    bus.cfg_dwell = 24'd5;
    bus.cfg_blank = 8'd2;
    exp_sel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run(cnt);
      check("auto_run", 32'(cnt), 32'd5);
      gap(cnt);
      check("auto_gap", 32'(cnt), 32'd2);
      exp_sel = ~exp_sel;
      check("auto_sel", 32'(bus.sel), 32'(exp_sel));
    end

    // Lowering cfg_dwell below the running count switches on the next edge
    for (int i = 0; i < 4; i++) tick();
    check("lower_pre_valid", 32'(bus.y_valid), 32'd1);
    bus.cfg_dwell = 24'd2;
    tick();
    check("lower_valid", 32'(bus.y_valid), 32'd0);
    check("lower_busy", 32'(bus.busy), 32'd1);
    gap(cnt);
    check("lower_gap", 32'(cnt), 32'd2);
    exp_sel = ~exp_sel;
    check("lower_sel", 32'(bus.sel), 32'(exp_sel));

    // cfg_dwell = 0 disables auto switching
    bus.cfg_dwell = 24'd0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!bus.y_valid) cnt++;
    end
    check("dwell0_invalid", 32'(cnt), 32'd0);
    check("dwell0_sel", 32'(bus.sel), 32'(exp_sel));

    // Asynchronous reset in the second blank cycle
    bus.cfg_auto  = 1'b0;
    bus.cfg_blank = 8'd4;
    bus.sel_req   = ~exp_sel;
    tick();
    tick();
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    check("arst_y", 32'(bus.y), 32'd0);
    check("arst_valid", 32'(bus.y_valid), 32'd0);
    check("arst_sel", 32'(bus.sel), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    bus.sel_req = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
    check("post_rst_y", 32'(bus.y), 32'd7);
    check("post_rst_valid", 32'(bus.y_valid), 32'd1);
    check("post_rst_sel", 32'(bus.sel), 32'd0);

`ifdef SIGNAL_SWITCH_STATS_EN
    bus.cfg_blank = 8'd1;
    for (int i = 0; i < 4; i++) begin
      bus.sel_req = ~bus.sel_req;
      tick();
      gap(cnt);
    end
    check("stats_count4", 32'(bus.switch_count), 32'd4);
    force dut.switch_count_reg = 16'hFFFF;
    #1;
    release dut.switch_count_reg;
    bus.sel_req = ~bus.sel_req;
    tick();
    gap(cnt);
    tick();
    check("stats_saturate", 32'(bus.switch_count), 32'h0000FFFF);
`endif

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
